// File: rtl/stream_mux_arb_pkg.sv
// Shared stream types: arbitration mode, lock-FSM states and the lowest-index first-one picker.
package stream_pkg;

    typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;
    typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

    localparam int MAX_CH = 32;

    // Isolates the lowest set bit; callers zero-extend narrower request vectors.
    function automatic logic [MAX_CH-1:0] first_one(input logic [MAX_CH-1:0] req);
        return req & (-req);
    endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// N producer streams plus one consumer stream; slave is the mux view, master the environment view.
interface stream_mux_arb_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational arbiter: round-robin from i_ptr when i_en_rr, else lowest index; zero latency, no state.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    input  logic            i_en_rr,
    output logic [N_CH-1:0] o_gnt,
    output logic [CH_W-1:0] o_gnt_idx,
    output logic            o_any
);

    logic [MAX_CH-1:0] w_fixed_oh;

    assign w_fixed_oh = first_one(MAX_CH'(i_req));

    // Scan from the farthest slot back to i_ptr so the closest requester is written last.
    always_comb begin
        int j;
        j         = 0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        if (i_en_rr) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                j = int'(i_ptr) + k;
                if (j >= N_CH) begin
                    j = j - N_CH;
                end
                if (i_req[j]) begin
                    o_any     = 1'b1;
                    o_gnt_idx = CH_W'(j);
                end
            end
        end else begin
            for (int k = MAX_CH - 1; k >= 0; k--) begin
                if (w_fixed_oh[k]) begin
                    o_any     = 1'b1;
                    o_gnt_idx = CH_W'(k);
                end
            end
        end
    end

    assign o_gnt = o_any ? (N_CH'(1) << o_gnt_idx) : '0;

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 stream mux with packet lock and one registered output stage; 1-cycle latency, 1 beat/cycle.
// A held output beat (out_valid & !out_ready) freezes out_* and drops every in_ready.
module stream_mux_arb
    import stream_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_arb_if.slave bus
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    lock_state_e      r_state;
    lock_state_e      w_state_nxt;
    logic [CH_W-1:0]  r_lock_ch;
    logic [CH_W-1:0]  r_rr_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [CH_W-1:0]  r_out_ch;

    logic [N_CH-1:0]  w_arb_gnt;
    logic [CH_W-1:0]  w_arb_idx;
    logic             w_arb_any;
    logic             w_locked;
    logic [N_CH-1:0]  w_gnt_oh;
    logic [CH_W-1:0]  w_gnt_idx;
    logic             w_gnt_act;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;
    int               w_sel_base;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .i_req     (bus.in_valid),
        .i_ptr     (r_rr_ptr),
        .i_en_rr   (ARB_MODE != int'(ARB_FIXED)),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    // While locked the arbiter result is ignored and only the lock owner can be served.
    assign w_locked    = (r_state == ST_LOCKED);
    assign w_gnt_idx   = w_locked ? r_lock_ch : w_arb_idx;
    assign w_gnt_oh    = w_locked ? (N_CH'(1) << r_lock_ch) : w_arb_gnt;
    assign w_gnt_act   = w_locked ? bus.in_valid[r_lock_ch] : w_arb_any;
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_accept    = w_gnt_act && w_slot_free;

    assign w_sel_base  = int'(w_gnt_idx) * WIDTH;
    assign w_sel_data  = bus.in_data[w_sel_base +: WIDTH];
    assign w_sel_last  = bus.in_last[w_gnt_idx];

    assign bus.in_ready  = w_accept ? w_gnt_oh : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_ch    = r_out_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_sel_last ? ST_UNLOCKED : ST_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_ch   <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            if (w_accept) begin
                if (!w_sel_last) begin
                    r_lock_ch <= w_gnt_idx;
                end
                r_rr_ptr    <= (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_last  <= w_sel_last;
                r_out_ch    <= w_gnt_idx;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: vector table on a round-robin instance plus reset and fixed-priority sequences.
module tb_stream_mux_arb;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    stream_mux_arb_if #(.N_CH(4), .WIDTH(8)) bus_rr ();
    stream_mux_arb_if #(.N_CH(4), .WIDTH(8)) bus_fx ();

    stream_mux_arb #(.N_CH(4), .WIDTH(8), .ARB_MODE(0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    stream_mux_arb #(.N_CH(4), .WIDTH(8), .ARB_MODE(1)) dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (bus_fx)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  erdy;
        logic        eov;
        logic [7:0]  eod;
        logic        eol;
        logic [1:0]  ech;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                       input logic [31:0] dat, input logic ordy, input logic [3:0] erdy,
                       input logic eov, input logic [7:0] eod, input logic eol, input logic [1:0] ech);
        vec_t v;
        v.rst = r;   v.vld = vld;   v.lst = lst; v.dat = dat; v.ordy = ordy;
        v.erdy = erdy; v.eov = eov; v.eod = eod; v.eol = eol; v.ech = ech;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_rr(input logic [3:0] vld, input logic [3:0] lst,
                            input logic [31:0] dat, input logic ordy);
        bus_rr.in_valid  = vld;
        bus_rr.in_last   = lst;
        bus_rr.in_data   = dat;
        bus_rr.out_ready = ordy;
    endtask

    task automatic drive_fx(input logic [3:0] vld, input logic [3:0] lst, input logic [31:0] dat);
        bus_fx.in_valid  = vld;
        bus_fx.in_last   = lst;
        bus_fx.in_data   = dat;
        bus_fx.out_ready = 1'b1;
    endtask

    localparam logic [31:0] BASE = 32'h44332211;

    initial begin
        //   rst   vld      lst      data          ordy  e_rdy    ov    od      ol    ch
        add(1'b1, 4'b0000, 4'b0000, BASE,         1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        // round-robin fairness, single-beat packets
        add(1'b0, 4'b1111, 4'b1111, BASE,         1'b1, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);
        add(1'b0, 4'b1111, 4'b1111, BASE,         1'b1, 4'b0010, 1'b1, 8'h22, 1'b1, 2'd1);
        add(1'b0, 4'b1111, 4'b1111, BASE,         1'b1, 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2);
        add(1'b0, 4'b1111, 4'b1111, BASE,         1'b1, 4'b1000, 1'b1, 8'h44, 1'b1, 2'd3);
        add(1'b0, 4'b1111, 4'b1111, BASE,         1'b1, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);
        // ch2 three-beat packet while ch0 waits
        add(1'b0, 4'b0101, 4'b0001, 32'h44A12211, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd2);
        add(1'b0, 4'b0101, 4'b0001, 32'h44A22211, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b0, 2'd2);
        add(1'b0, 4'b0101, 4'b0101, 32'h44A32211, 1'b1, 4'b0100, 1'b1, 8'hA3, 1'b1, 2'd2);
        add(1'b0, 4'b0001, 4'b0001, BASE,         1'b1, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);
        // ch1 locks, drops valid mid-packet: stall, others not served
        add(1'b0, 4'b0010, 4'b0000, 32'h4433B111, 1'b1, 4'b0010, 1'b1, 8'hB1, 1'b0, 2'd1);
        add(1'b0, 4'b1001, 4'b1001, 32'h4433B111, 1'b1, 4'b0000, 1'b0, 8'hB1, 1'b0, 2'd1);
        add(1'b0, 4'b1011, 4'b1011, 32'h4433B211, 1'b1, 4'b0010, 1'b1, 8'hB2, 1'b1, 2'd1);
        add(1'b0, 4'b1001, 4'b1001, BASE,         1'b1, 4'b1000, 1'b1, 8'h44, 1'b1, 2'd3);
        // back-pressure for 5 cycles, then release
        for (int c = 0; c < 5; c++)
            add(1'b0, 4'b0001, 4'b0001, BASE,     1'b0, 4'b0000, 1'b1, 8'h44, 1'b1, 2'd3);
        add(1'b0, 4'b0001, 4'b0001, BASE,         1'b1, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 4'b0000, BASE,         1'b1, 4'b0000, 1'b0, 8'h11, 1'b1, 2'd0);

        rst = 1'b1;
        drive_rr(4'b0000, 4'b0000, BASE, 1'b1);
        drive_fx(4'b0000, 4'b0000, BASE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle%0d in_ready", c), 32'(bus_rr.in_ready), 32'h0);
            chk($sformatf("idle%0d out_valid", c), 32'(bus_rr.out_valid), 32'h0);
        end

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            rst = tv[k].rst;
            drive_rr(tv[k].vld, tv[k].lst, tv[k].dat, tv[k].ordy);
            #1;
            chk($sformatf("v%0d in_ready", k), 32'(bus_rr.in_ready), 32'(tv[k].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", k), 32'(bus_rr.out_valid), 32'(tv[k].eov));
            chk($sformatf("v%0d out_data", k), 32'(bus_rr.out_data), 32'(tv[k].eod));
            chk($sformatf("v%0d out_last", k), 32'(bus_rr.out_last), 32'(tv[k].eol));
            chk($sformatf("v%0d out_ch", k), 32'(bus_rr.out_ch), 32'(tv[k].ech));
        end

        // mid-packet reset: ch1 locked after two beats, then ch3 must be served first
        @(negedge clk);
        drive_rr(4'b0010, 4'b0000, 32'h4433C111, 1'b1);
        @(posedge clk); #1;
        chk("mpr beat1 out_ch", 32'(bus_rr.out_ch), 32'd1);
        @(negedge clk);
        drive_rr(4'b0010, 4'b0000, 32'h4433C211, 1'b1);
        @(posedge clk); #1;
        chk("mpr beat2 out_data", 32'(bus_rr.out_data), 32'hC2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mpr rst out_valid", 32'(bus_rr.out_valid), 32'h0);
        chk("mpr rst out_data", 32'(bus_rr.out_data), 32'h0);
        chk("mpr rst out_ch", 32'(bus_rr.out_ch), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_rr(4'b1000, 4'b1000, 32'hD3332211, 1'b1);
        #1;
        chk("mpr after in_ready", 32'(bus_rr.in_ready), 32'b1000);
        @(posedge clk); #1;
        chk("mpr after out_valid", 32'(bus_rr.out_valid), 32'h1);
        chk("mpr after out_ch", 32'(bus_rr.out_ch), 32'd3);
        chk("mpr after out_data", 32'(bus_rr.out_data), 32'hD3);
        @(negedge clk);
        drive_rr(4'b0000, 4'b0000, BASE, 1'b1);

        // fixed priority: ch1 beats ch3 every time, ch3 only once ch1 is idle, ch0 beats both
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_fx(4'b1010, 4'b1010, 32'h77335511);
            #1;
            chk($sformatf("fx%0d in_ready", c), 32'(bus_fx.in_ready), 32'b0010);
            @(posedge clk); #1;
            chk($sformatf("fx%0d out_ch", c), 32'(bus_fx.out_ch), 32'd1);
            chk($sformatf("fx%0d out_data", c), 32'(bus_fx.out_data), 32'h55);
        end
        @(negedge clk);
        drive_fx(4'b1000, 4'b1000, 32'h77335511);
        #1;
        chk("fx ch3 in_ready", 32'(bus_fx.in_ready), 32'b1000);
        @(posedge clk); #1;
        chk("fx ch3 out_ch", 32'(bus_fx.out_ch), 32'd3);
        chk("fx ch3 out_data", 32'(bus_fx.out_data), 32'h77);
        @(negedge clk);
        drive_fx(4'b1011, 4'b1011, 32'h77335566);
        #1;
        chk("fx ch0 in_ready", 32'(bus_fx.in_ready), 32'b0001);
        @(posedge clk); #1;
        chk("fx ch0 out_ch", 32'(bus_fx.out_ch), 32'd0);
        chk("fx ch0 out_data", 32'(bus_fx.out_data), 32'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
